// File: rtl/uart_rx_core.sv
`timescale 1ns/1ps
// Purpose : 8N1 UART receiver (start, 8 data LSB first, stop) with a small FWFT receive FIFO.
// Latency : a byte is visible on rx_valid_o 1 clk after its stop-bit decision sample.
// Backpr. : rx_ready_i pops the FIFO head; a byte arriving with the FIFO full is dropped and sets overflow_o.
//
// Ports:
//   clk_i, rst_n_i   system clock, asynchronous active-low reset
//   baud_div_i       clk cycles per sample tick (0 behaves as 1), latched at start detection
//   rx_i             asynchronous serial input, idle high
//   rx_data_o        head-of-FIFO byte; rx_valid_o = FIFO not empty; rx_ready_i pops
//   frame_err_o      sticky, stop bit sampled low; overflow_o sticky, byte lost to a full FIFO
//   err_clr_i        clears both sticky flags (a set in the same cycle wins)
//   busy_o           receiver is inside a frame
//
// Build option: define UART_RX_MAJORITY_EN to decide every bit by a 2-of-3 vote over the
// ticks centre-1, centre and centre+1 (decision at centre+1). Otherwise one centre sample.
module uart_rx_core #(
  parameter int SAMPLE_NUM = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [DIV_W-1:0] baud_div_i,
  input  logic             rx_i,
  output logic [7:0]       rx_data_o,
  output logic             rx_valid_o,
  input  logic             rx_ready_i,
  output logic             frame_err_o,
  output logic             overflow_o,
  input  logic             err_clr_i,
  output logic             busy_o
);

  localparam int SW = $clog2(SAMPLE_NUM);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

`ifdef UART_RX_MAJORITY_EN
  localparam int DEC_OFS = 1;
`else
  localparam int DEC_OFS = 0;
`endif

  // Tick index (within the start bit) at which the start bit is decided; every later
  // decision is exactly SAMPLE_NUM ticks after the previous one.
  localparam logic [SW-1:0] START_PT = SW'(SAMPLE_NUM/2 - 1 + DEC_OFS);
  localparam logic [SW-1:0] BIT_PT   = SW'(SAMPLE_NUM - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic [1:0]       state;
  logic             rx_meta;
  logic             rx_s;
  logic             rx_prev;
  logic             fall;
  logic [DIV_W-1:0] div_lat;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [SW-1:0]    samp_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic             bit_val;
  logic             stop_done;
  logic             push;
  logic             frame_err_set;

  // ---------------- input synchronizer and falling-edge detect ----------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  // Only an edge starts a frame, so a line stuck low after a bad stop bit cannot re-trigger.
  assign fall = rx_prev & ~rx_s;

  // ---------------- sample-tick divider ----------------
  assign busy_o = (state != ST_IDLE);
  assign tick   = busy_o && (div_cnt == div_lat - DIV_W'(1));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      div_lat <= DIV_W'(1);
      div_cnt <= '0;
    end else if (state == ST_IDLE) begin
      // Held at 0 while idle so the first tick lands one full divider period after the edge.
      div_cnt <= '0;
      if (fall) begin
        div_lat <= (baud_div_i == '0) ? DIV_W'(1) : baud_div_i;
      end
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // ---------------- bit value decision ----------------
`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hist <= 2'b11;
    end else if (state == ST_IDLE) begin
      hist <= 2'b11;
    end else if (tick) begin
      hist <= {hist[0], rx_s};
    end
  end

  // hist holds the two previous ticks' samples; rx_s is the current (centre+1) tick.
  assign bit_val = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
  assign bit_val = rx_s;
`endif

  // ---------------- frame FSM ----------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= ST_IDLE;
      samp_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (fall) begin
            state    <= ST_START;
            samp_cnt <= '0;
          end
        end
        ST_START: begin
          if (tick) begin
            if (samp_cnt == START_PT) begin
              samp_cnt <= '0;
              if (bit_val) begin
                state <= ST_IDLE;       // line went back high: glitch, not a start bit
              end else begin
                state   <= ST_DATA;
                bit_cnt <= '0;
              end
            end else begin
              samp_cnt <= samp_cnt + SW'(1);
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (samp_cnt == BIT_PT) begin
              samp_cnt <= '0;
              shreg    <= {bit_val, shreg[7:1]};
              if (bit_cnt == 3'd7) begin
                state <= ST_STOP;
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
              end
            end else begin
              samp_cnt <= samp_cnt + SW'(1);
            end
          end
        end
        default: begin // ST_STOP
          if (tick) begin
            if (samp_cnt == BIT_PT) begin
              // Leaving at the stop-bit centre leaves half a bit to catch a back-to-back start.
              samp_cnt <= '0;
              state    <= ST_IDLE;
            end else begin
              samp_cnt <= samp_cnt + SW'(1);
            end
          end
        end
      endcase
    end
  end

  assign stop_done     = (state == ST_STOP) && tick && (samp_cnt == BIT_PT);
  assign push          = stop_done && bit_val;
  assign frame_err_set = stop_done && !bit_val;

  // ---------------- receive FIFO (first-word fall-through) ----------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          pop;
  logic          wr_en;
  logic          ovf_set;

  assign full    = (count == CW'(FIFO_DEPTH));
  assign pop     = rx_ready_i && (count != '0);
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign wr_en   = push && (!full || pop);
  assign ovf_set = push && full && !pop;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= shreg;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_en, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign rx_data_o  = mem[rd_ptr];
  assign rx_valid_o = (count != '0);

  // ---------------- sticky error flags ----------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      frame_err_o <= 1'b0;
      overflow_o  <= 1'b0;
    end else begin
      if (frame_err_set) begin
        frame_err_o <= 1'b1;
      end else if (err_clr_i) begin
        frame_err_o <= 1'b0;
      end
      if (ovf_set) begin
        overflow_o <= 1'b1;
      end else if (err_clr_i) begin
        overflow_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
`timescale 1ns/1ps
// Bench for uart_rx_core: a serial line driver plus a byte-queue model of the receiver.
// The model is updated once per transmitted frame and compared against the DUT every
// cycle outside the stop-bit window; literal checks pin the model at key points.
module tb_uart_rx_core;

  localparam int CLK_NS = 20;
  localparam int DIV    = 27;
  localparam int SNUM   = 16;
  localparam int DEPTH  = 4;
  localparam int BIT_NS = DIV * SNUM * CLK_NS;

  logic        clk = 1'b0;
  logic        rst_n_i;
  logic [15:0] baud_div_i;
  logic        rx_i;
  logic [7:0]  rx_data_o;
  logic        rx_valid_o;
  logic        rx_ready_i;
  logic        frame_err_o;
  logic        overflow_o;
  logic        err_clr_i;
  logic        busy_o;

  always #(CLK_NS/2) clk = ~clk;

  uart_rx_core #(.SAMPLE_NUM(SNUM), .FIFO_DEPTH(DEPTH), .DIV_W(16)) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n_i),
    .baud_div_i (baud_div_i),
    .rx_i       (rx_i),
    .rx_data_o  (rx_data_o),
    .rx_valid_o (rx_valid_o),
    .rx_ready_i (rx_ready_i),
    .frame_err_o(frame_err_o),
    .overflow_o (overflow_o),
    .err_clr_i  (err_clr_i),
    .busy_o     (busy_o)
  );

  int checks = 0;
  int errors = 0;

  // Receiver model: bytes waiting to be read, and the two sticky flags.
  logic [7:0] mq[$];
  logic       m_ovf = 1'b0;
  logic       m_fe  = 1'b0;
  logic       settled = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, then apply this cycle's pop / clear to it.
  always @(negedge clk) begin
    if (settled && rst_n_i) begin
      check("m_valid", {31'd0, rx_valid_o}, {31'd0, mq.size() != 0});
      if (mq.size() != 0) check("m_data", {24'd0, rx_data_o}, {24'd0, mq[0]});
      check("m_ovf", {31'd0, overflow_o}, {31'd0, m_ovf});
      check("m_fe", {31'd0, frame_err_o}, {31'd0, m_fe});
      if (rx_ready_i && mq.size() != 0) void'(mq.pop_front());
      if (err_clr_i) begin
        m_ovf = 1'b0;
        m_fe  = 1'b0;
      end
    end
  end

  // One 8N1 frame. glitch_bit >= 0 inverts a 20-clk window around that data bit's centre.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int glitch_bit);
    logic v;
    rx_i = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 8; i++) begin
      v = d[i];
      rx_i = v;
      if (i == glitch_bit) begin
        #(BIT_NS/2 - 5*CLK_NS);
        rx_i = ~v;
        #(20*CLK_NS);
        rx_i = v;
        #(BIT_NS/2 - 15*CLK_NS);
      end else begin
        #(BIT_NS);
      end
    end
    settled = 1'b0;
    rx_i = stop;
    #(BIT_NS);
    if (stop) begin
      if (mq.size() == DEPTH) m_ovf = 1'b1;
      else mq.push_back(d);
    end else begin
      m_fe = 1'b1;
    end
    settled = 1'b1;
  endtask

  task automatic pop_one();
    @(posedge clk); #2 rx_ready_i = 1'b1;
    @(posedge clk); #2 rx_ready_i = 1'b0;
  endtask

  task automatic clr_pulse();
    @(posedge clk); #2 err_clr_i = 1'b1;
    @(posedge clk); #2 err_clr_i = 1'b0;
  endtask

  task automatic align();
    @(posedge clk); #1;
  endtask

  initial begin
    #(95000 * CLK_NS);
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [7:0] exp4 [4];

  initial begin
    exp4 = '{8'h00, 8'hFF, 8'h55, 8'h3C};
    rst_n_i    = 1'b0;
    baud_div_i = 16'(DIV);
    rx_i       = 1'b1;
    rx_ready_i = 1'b0;
    err_clr_i  = 1'b0;
    #15;
    check("rst_valid", {31'd0, rx_valid_o}, 32'd0);
    check("rst_data", {24'd0, rx_data_o}, 32'd0);
    check("rst_fe", {31'd0, frame_err_o}, 32'd0);
    check("rst_ovf", {31'd0, overflow_o}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    align();
    rst_n_i = 1'b1;
    repeat (5) @(posedge clk);
    #1 settled = 1'b1;

    // 1: single byte, then pop
    align();
    send_frame(8'hA5, 1'b1, -1);
    check("t1_valid", {31'd0, rx_valid_o}, 32'd1);
    check("t1_data", {24'd0, rx_data_o}, 32'hA5);
    check("t1_flags", {30'd0, frame_err_o, overflow_o}, 32'd0);
    pop_one();
    repeat (2) @(posedge clk); #1;
    check("t1_empty", {31'd0, rx_valid_o}, 32'd0);

    // 2: four back-to-back bytes fill the FIFO
    align();
    for (int i = 0; i < 4; i++) send_frame(exp4[i], 1'b1, -1);
    check("t2_ovf", {31'd0, overflow_o}, 32'd0);
    check("t2_head", {24'd0, rx_data_o}, 32'h00);

    // 3: fifth byte overflows; contents unchanged
    send_frame(8'h81, 1'b1, -1);
    check("t3_ovf", {31'd0, overflow_o}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t3_drain", {24'd0, rx_data_o}, {24'd0, exp4[i]});
      pop_one();
    end
    repeat (2) @(posedge clk); #1;
    check("t3_empty", {31'd0, rx_valid_o}, 32'd0);
    clr_pulse();
    repeat (2) @(posedge clk); #1;
    check("t3_clr", {31'd0, overflow_o}, 32'd0);

    // 4: framing error, then a good frame
    align();
    send_frame(8'h5A, 1'b0, -1);
    rx_i = 1'b1;
    #(2*BIT_NS);
    check("t4_fe", {31'd0, frame_err_o}, 32'd1);
    check("t4_nopush", {31'd0, rx_valid_o}, 32'd0);
    align();
    send_frame(8'h12, 1'b1, -1);
    check("t4_data", {24'd0, rx_data_o}, 32'h12);
    clr_pulse();
    repeat (2) @(posedge clk); #1;
    check("t4_clr", {31'd0, frame_err_o}, 32'd0);

    // 5: short low pulse is rejected as a false start
    align();
    rx_i = 1'b0;
    #(4*DIV*CLK_NS);
    rx_i = 1'b1;
    check("t5_busy", {31'd0, busy_o}, 32'd1);
    #(20*DIV*CLK_NS);
    check("t5_idle", {31'd0, busy_o}, 32'd0);
    check("t5_flags", {30'd0, frame_err_o, overflow_o}, 32'd0);
    check("t5_head", {24'd0, rx_data_o}, 32'h12);

    // 6: reset in the middle of frame 0x77 (FIFO holds 0x12)
    align();
    rx_i = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 3; i++) begin
      rx_i = (i == 3) ? 1'b0 : 1'b1;   // bits 0..2 of 0x77 are 1
      #(BIT_NS);
    end
    rx_i = 1'b0;                       // bit 3 of 0x77
    #(BIT_NS/2);
    check("t6_busy", {31'd0, busy_o}, 32'd1);
    settled = 1'b0;
    rst_n_i = 1'b0;
    #1;
    check("t6_valid", {31'd0, rx_valid_o}, 32'd0);
    check("t6_data", {24'd0, rx_data_o}, 32'd0);
    check("t6_flags", {30'd0, frame_err_o, overflow_o}, 32'd0);
    check("t6_idle", {31'd0, busy_o}, 32'd0);
    mq.delete();
    m_ovf = 1'b0;
    m_fe  = 1'b0;
    rx_i  = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst_n_i = 1'b1;
    repeat (5) @(posedge clk);
    #1 settled = 1'b1;
    send_frame(8'h33, 1'b1, -1);
    check("t6_rx", {24'd0, rx_data_o}, 32'h33);
    pop_one();

`ifdef UART_RX_MAJORITY_EN
    // glitch at the centre of bit 3 is outvoted
    align();
    send_frame(8'hF0, 1'b1, 3);
    check("maj_data", {24'd0, rx_data_o}, 32'hF0);
    check("maj_valid", {31'd0, rx_valid_o}, 32'd1);
    pop_one();
`endif

    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
